// File: rtl/fusion_ctrl_pkg.sv
// Shared types and precision helpers for the fusion column controller.
// Precision codes are one-hot: bit k set means 2**k bits per element.
package fusion_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        COMPUTE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [3:0] W1 = 4'b0001;
    localparam logic [3:0] W2 = 4'b0010;
    localparam logic [3:0] W4 = 4'b0100;
    localparam logic [3:0] W8 = 4'b1000;

    function automatic logic is_legal_width(input logic [3:0] w);
        return (w == W1) || (w == W2) || (w == W4) || (w == W8);
    endfunction

endpackage

// File: rtl/fusion_column_ctrl_valid_pipe.sv
// Tag shift register that follows each issued vector down the column.
// Advances every cycle; the tail lines up with the column's psum output.
module fusion_valid_pipe
    import fusion_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic in_last,
    output logic out_valid,
    output logic out_last,
    output logic empty
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [DEPTH-1:0] lst_q;
    logic [DEPTH-1:0] lst_d;

    always_comb begin
        vld_d = {vld_q[DEPTH-2:0], in_valid};
        lst_d = {lst_q[DEPTH-2:0], in_valid & in_last};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            vld_q <= vld_d;
            lst_q <= lst_d;
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_last  = lst_q[DEPTH-1];

    // Nothing remains once the current tail leaves this cycle.
    assign empty = ~|vld_q[DEPTH-2:0];

endmodule

// File: rtl/fusion_column_ctrl.sv
// Job sequencer for one column of chained fusion units: weight load,
// activation streaming with stalls, and output-valid tagging.
module fusion_column_ctrl
    import fusion_ctrl_pkg::*;
#(
    parameter int ROWS      = 8,
    parameter int VEC_CNT_W = 16,
    parameter int ROW_IDX_W = $clog2(ROWS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [3:0]           cfg_in_width,
    input  logic [3:0]           cfg_weight_width,
    input  logic                 cfg_s_in,
    input  logic                 cfg_s_weight,
    input  logic [VEC_CNT_W-1:0] cfg_num_vec,
    output logic                 cfg_err,
    input  logic                 w_ready,
    output logic                 w_load_en,
    output logic [ROW_IDX_W-1:0] w_load_row,
    input  logic                 act_ready,
    output logic                 act_rd,
    output logic [3:0]           arr_in_width,
    output logic [3:0]           arr_weight_width,
    output logic                 arr_s_in,
    output logic                 arr_s_weight,
    output logic                 psum_clear,
    output logic                 out_valid,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ROWS - 1);

    state_t               state_q;
    state_t               state_d;
    logic [ROW_IDX_W-1:0] row_cnt_q;
    logic [ROW_IDX_W-1:0] row_cnt_d;
    logic [VEC_CNT_W-1:0] vec_cnt_q;
    logic [VEC_CNT_W-1:0] vec_cnt_d;
    logic [VEC_CNT_W-1:0] num_vec_q;
    logic [VEC_CNT_W-1:0] num_vec_d;
    logic [3:0]           in_width_q;
    logic [3:0]           in_width_d;
    logic [3:0]           wt_width_q;
    logic [3:0]           wt_width_d;
    logic                 s_in_q;
    logic                 s_in_d;
    logic                 s_wt_q;
    logic                 s_wt_d;
    logic                 cfg_err_q;
    logic                 cfg_err_d;

    logic                 cfg_legal;
    logic                 load_c;
    logic                 issue_c;
    logic                 last_c;
    logic                 pipe_empty;

    assign cfg_legal = is_legal_width(cfg_in_width)
                     & is_legal_width(cfg_weight_width);

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        vec_cnt_d  = vec_cnt_q;
        num_vec_d  = num_vec_q;
        in_width_d = in_width_q;
        wt_width_d = wt_width_q;
        s_in_d     = s_in_q;
        s_wt_d     = s_wt_q;
        cfg_err_d  = 1'b0;
        load_c     = 1'b0;
        issue_c    = 1'b0;
        last_c     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_legal) begin
                    in_width_d = cfg_in_width;
                    wt_width_d = cfg_weight_width;
                    s_in_d     = cfg_s_in;
                    s_wt_d     = cfg_s_weight;
                    num_vec_d  = cfg_num_vec;
                    row_cnt_d  = '0;
                    vec_cnt_d  = '0;
                    state_d    = (cfg_num_vec == '0) ? DONE : LOAD_W;
                end else if (cfg_valid) begin
                    cfg_err_d = 1'b1;
                end
            end
            LOAD_W: begin
                if (w_ready) begin
                    load_c = 1'b1;
                    if (row_cnt_q == LAST_ROW) begin
                        row_cnt_d = '0;
                        state_d   = COMPUTE;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            COMPUTE: begin
                if (act_ready) begin
                    issue_c   = 1'b1;
                    vec_cnt_d = vec_cnt_q + 1'b1;
                    // Final vector of the job closes the issue window.
                    if (vec_cnt_q == num_vec_q - VEC_CNT_W'(1)) begin
                        last_c  = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_cnt_q  <= '0;
            vec_cnt_q  <= '0;
            num_vec_q  <= '0;
            in_width_q <= W8;
            wt_width_q <= W8;
            s_in_q     <= 1'b0;
            s_wt_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            vec_cnt_q  <= vec_cnt_d;
            num_vec_q  <= num_vec_d;
            in_width_q <= in_width_d;
            wt_width_q <= wt_width_d;
            s_in_q     <= s_in_d;
            s_wt_q     <= s_wt_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    fusion_valid_pipe #(
        .DEPTH(ROWS)
    ) u_valid_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (issue_c),
        .in_last  (last_c),
        .out_valid(out_valid),
        .out_last (out_last),
        .empty    (pipe_empty)
    );

    assign cfg_ready        = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign cfg_err          = cfg_err_q;
    assign w_load_en        = load_c;
    assign w_load_row       = row_cnt_q;
    assign act_rd           = issue_c;
    assign psum_clear       = ~issue_c;
    assign arr_in_width     = in_width_q;
    assign arr_weight_width = wt_width_q;
    assign arr_s_in         = s_in_q;
    assign arr_s_weight     = s_wt_q;

endmodule

// File: tb/tb_fusion_column_ctrl.sv
// Randomized bench for fusion_column_ctrl against a job-level reference
// model built from load/issue counts and an output-time queue.
module tb_fusion_column_ctrl;

    localparam int ROWS = 8;
    localparam int VW   = 16;
    localparam int RW   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [3:0]    cfg_in_width = 4'b1000;
    logic [3:0]    cfg_weight_width = 4'b1000;
    logic          cfg_s_in = 1'b0;
    logic          cfg_s_weight = 1'b0;
    logic [VW-1:0] cfg_num_vec = '0;
    logic          cfg_err;
    logic          w_ready = 1'b0;
    logic          w_load_en;
    logic [RW-1:0] w_load_row;
    logic          act_ready = 1'b0;
    logic          act_rd;
    logic [3:0]    arr_in_width;
    logic [3:0]    arr_weight_width;
    logic          arr_s_in;
    logic          arr_s_weight;
    logic          psum_clear;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          done;

    fusion_column_ctrl #(
        .ROWS(ROWS),
        .VEC_CNT_W(VW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_in_width    (cfg_in_width),
        .cfg_weight_width(cfg_weight_width),
        .cfg_s_in        (cfg_s_in),
        .cfg_s_weight    (cfg_s_weight),
        .cfg_num_vec     (cfg_num_vec),
        .cfg_err         (cfg_err),
        .w_ready         (w_ready),
        .w_load_en       (w_load_en),
        .w_load_row      (w_load_row),
        .act_ready       (act_ready),
        .act_rd          (act_rd),
        .arr_in_width    (arr_in_width),
        .arr_weight_width(arr_weight_width),
        .arr_s_in        (arr_s_in),
        .arr_s_weight    (arr_s_weight),
        .psum_clear      (psum_clear),
        .out_valid       (out_valid),
        .out_last        (out_last),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: a job is weights-then-vectors counted in plain ints;
    // each issued vector is scheduled to appear ROWS cycles later.
    typedef struct {
        int t;
        bit last;
    } tag_t;

    tag_t       outq[$];
    bit         armed = 0;
    bit         m_busy;
    int         m_rows, m_issued, m_nv, m_done_at, m_err_at;
    logic [3:0] m_iw, m_ww;
    logic       m_si, m_sw;

    always @(negedge clk) begin
        bit loading, computing, e_rd, e_ov, e_ol, e_done;
        loading   = m_busy && m_nv > 0 && m_rows < ROWS;
        computing = m_busy && m_nv > 0 && m_rows == ROWS && m_issued < m_nv;
        e_rd      = computing && act_ready;
        e_ov      = outq.size() > 0 && outq[0].t == cyc;
        e_ol      = e_ov && outq[0].last;
        e_done    = m_busy && cyc == m_done_at;
        if (armed) begin
            check("cfg_ready", 32'(cfg_ready), 32'(!m_busy));
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(e_done));
            check("cfg_err", 32'(cfg_err), 32'(cyc == m_err_at));
            check("w_load_en", 32'(w_load_en), 32'(loading && w_ready));
            if (loading && w_ready)
                check("w_load_row", 32'(w_load_row), 32'(m_rows));
            check("act_rd", 32'(act_rd), 32'(e_rd));
            check("psum_clear", 32'(psum_clear), 32'(!e_rd));
            check("out_valid", 32'(out_valid), 32'(e_ov));
            check("out_last", 32'(out_last), 32'(e_ol));
            check("arr_in_width", 32'(arr_in_width), 32'(m_iw));
            check("arr_wt_width", 32'(arr_weight_width), 32'(m_ww));
            check("arr_s_in", 32'(arr_s_in), 32'(m_si));
            check("arr_s_weight", 32'(arr_s_weight), 32'(m_sw));
        end
        if (!rst_n) begin
            armed     = 1;
            m_busy    = 0;
            m_rows    = 0;
            m_issued  = 0;
            m_nv      = 0;
            m_done_at = -1;
            m_err_at  = -1;
            m_iw      = 4'b1000;
            m_ww      = 4'b1000;
            m_si      = 0;
            m_sw      = 0;
            outq.delete();
        end else if (armed) begin
            if (!m_busy && cfg_valid) begin
                if ($onehot(cfg_in_width) && $onehot(cfg_weight_width)) begin
                    m_iw     = cfg_in_width;
                    m_ww     = cfg_weight_width;
                    m_si     = cfg_s_in;
                    m_sw     = cfg_s_weight;
                    m_busy   = 1;
                    m_rows   = 0;
                    m_issued = 0;
                    m_nv     = int'(cfg_num_vec);
                    if (m_nv == 0) m_done_at = cyc + 1;
                end else begin
                    m_err_at = cyc + 1;
                end
            end else if (m_busy) begin
                if (loading && w_ready) m_rows++;
                if (e_rd) begin
                    outq.push_back('{t: cyc + ROWS, last: (m_issued == m_nv - 1)});
                    m_issued++;
                end
                if (e_ol) m_done_at = cyc + 1;
                if (e_done) m_busy = 0;
            end
            if (e_ov) void'(outq.pop_front());
        end
    end

    function automatic logic rdy(input int m, input int i);
        case (m)
            0: return 1'b1;
            1: return i[0];
            2: return $urandom_range(0, 9) < 7;
            3: return !(i == 11 || i == 12);
            default: return 1'b1;
        endcase
    endfunction

    // One job: descriptor in cycle 0, then run until the controller idles.
    task automatic job(input logic [3:0] iw, input logic [3:0] ww,
                       input logic si, input logic sw, input int nv,
                       input int wm, input int am, input int rst_at,
                       input bit junk);
        for (int i = 0; i < 400; i++) begin
            rst_n     = (i != rst_at);
            w_ready   = rdy(wm, i);
            act_ready = rdy(am, i);
            if (i == 0) begin
                cfg_valid        = 1'b1;
                cfg_in_width     = iw;
                cfg_weight_width = ww;
                cfg_s_in         = si;
                cfg_s_weight     = sw;
                cfg_num_vec      = VW'(nv);
            end else begin
                cfg_valid        = junk && ($urandom_range(0, 3) == 0);
                cfg_in_width     = 4'(1 << $urandom_range(0, 3));
                cfg_weight_width = 4'(1 << $urandom_range(0, 3));
                cfg_s_in         = 1'($urandom_range(0, 1));
                cfg_s_weight     = 1'($urandom_range(0, 1));
                cfg_num_vec      = VW'($urandom_range(0, 3));
            end
            @(posedge clk);
            #1;
            if (i > 0 && !busy) break;
        end
        check("job_end_idle", 32'(busy), 32'(0));
        cfg_valid = 1'b0;
        rst_n     = 1'b1;
    endtask

    initial begin
        logic [3:0] iw, ww;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        job(4'b1000, 4'b1000, 0, 0, 4, 0, 0, -1, 0);
        job(4'b1000, 4'b1000, 0, 0, 4, 0, 3, -1, 0);
        job(4'b1000, 4'b1000, 0, 0, 4, 1, 0, -1, 0);
        job(4'b0011, 4'b1000, 0, 0, 4, 0, 0, -1, 0);
        job(4'b0010, 4'b0100, 1, 1, 3, 0, 0, -1, 0);
        job(4'b1000, 4'b1000, 0, 0, 0, 0, 0, -1, 0);
        job(4'b0001, 4'b0010, 1, 0, 6, 0, 0, 11, 0);
        for (int j = 0; j < 60; j++) begin
            iw = ($urandom_range(0, 4) == 0) ? 4'($urandom)
                                             : 4'(1 << $urandom_range(0, 3));
            ww = ($urandom_range(0, 4) == 0) ? 4'($urandom)
                                             : 4'(1 << $urandom_range(0, 3));
            job(iw, ww, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 9), 2, 2,
                ($urandom_range(0, 9) == 0) ? $urandom_range(1, 30) : -1, 1);
        end
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
